// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus: ifetch_unit is the master (requests, takes responses), imem is the slave.
interface ifetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/ifetch_unit.sv
// MIPS fetch front end: PC sequencing, credit-limited imem requests, 2-entry {inst, pc} buffer, redirect flush.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects (sticky fetch_misalign, HALT until reset).
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    ifetch_unit_if.master        imem,
    output logic                 inst_valid,
    output logic [31:0]          inst,
    output logic [31:0]          inst_pc,
    input  logic                 inst_ready,
    output logic                 fetch_misalign
);
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    logic [1:0]  outstanding;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic [31:0] buf_inst [2];
    logic [31:0] buf_pc   [2];

    logic [31:0] target;
    logic        target_bad;
    logic        credit, redir, acc, rsp_dec, push, pop;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
`else
    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign target_bad = 1'b0;
`endif

    // In-flight requests reserve buffer slots, so a response always finds room.
    assign credit  = ({1'b0, outstanding} + {1'b0, count}) < 3'd2;
    assign redir   = redirect_valid && ((state == RUN) || (state == FLUSH));
    assign acc     = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_dec = imem.imem_rsp_valid && (outstanding != 2'd0);
    assign push    = imem.imem_rsp_valid && (state == RUN) && !redir;
    assign pop     = inst_valid && inst_ready;

    assign imem.imem_req_valid = (state == RUN) && credit;
    assign imem.imem_req_addr  = fetch_pc;
    assign inst_valid          = (count != 2'd0);
    assign inst                = buf_inst[rd_ptr];
    assign inst_pc             = buf_pc[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (redir) state_nxt = target_bad ? HALT : FLUSH;
            FLUSH: begin
                if (redir && target_bad)
                    state_nxt = HALT;
                else if (outstanding == 2'd0)
                    state_nxt = RUN;
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= 2'd0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding + {1'b0, acc} - {1'b0, rsp_dec};
            if (redir && !target_bad) begin
                fetch_pc <= target;
                rsp_pc   <= target;
            end else begin
                if (acc)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push)
                    rsp_pc <= rsp_pc + 32'd4;
            end
            // A pop in the redirect cycle completes, then the whole buffer is dropped.
            if (redir) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                count  <= count + {1'b0, push} - {1'b0, pop};
                rd_ptr <= rd_ptr ^ pop;
                wr_ptr <= wr_ptr ^ push;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_inst[0] <= 32'd0;
            buf_inst[1] <= 32'd0;
            buf_pc[0]   <= 32'd0;
            buf_pc[1]   <= 32'd0;
        end else if (push) begin
            buf_inst[wr_ptr] <= imem.imem_rsp_data;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            misalign_q <= 1'b0;
        else if (redir && target_bad)
            misalign_q <= 1'b1;
    end

    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif
endmodule
